// File: rtl/alu_pkg.sv
// Shared ALU definitions: the operation encoding and the add/subtract decode
// used by every datapath that instantiates the ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // SUB shares the adder by inverting operand 2 and injecting a carry.
    function automatic logic op_uses_sub(input alu_op_t op);
        return (op == ALU_SUB);
    endfunction

endpackage : alu_pkg

// File: rtl/regfile_np.sv
// Parametrised register file: two read ports, a debug read/write port and a
// retire write port. Register 0 always reads as zero.
module regfile_np #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata
);

    logic [XLEN-1:0] r_mem [NREG];

    // NOTE: this array is cleared on reset because the datapath must observe
    // all-zero registers afterwards; that forces flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                // NOTE: non-blocking so every flop samples pre-edge values.
                r_mem[i] <= '0;
            end
        end else begin
            if (dbg_we && (dbg_addr != '0)) begin
                r_mem[dbg_addr] <= dbg_wdata;
            end
            // Placed last so a retire to the same address overrides debug.
            if (wr_en && (wr_addr != '0)) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign rd1       = (ra1 == '0)      ? '0 : r_mem[ra1];
    assign rd2       = (ra2 == '0)      ? '0 : r_mem[ra2];
    assign dbg_rdata = (dbg_addr == '0) ? '0 : r_mem[dbg_addr];

endmodule : regfile_np

// File: rtl/datapath_pipe.sv
// Two-stage register-file + ALU datapath with issue/result handshakes,
// EX-to-issue forwarding, debug register access and a retire counter.
module datapath_pipe
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic            reg_write,
    input  alu_op_t         alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [AW-1:0]   out_rd,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic [XLEN-1:0] dbg_rdata,
    output logic [31:0]     retire_cnt
);

    localparam int SHW = $clog2(XLEN);

    logic            r_ex_valid;
    logic            r_ex_we;
    logic [AW-1:0]   r_ex_rd;
    logic [XLEN-1:0] r_ex_result;
    logic [31:0]     r_retire_cnt;

    logic            w_accept;
    logic            w_retire;
    logic [XLEN-1:0] w_rf_rd1;
    logic [XLEN-1:0] w_rf_rd2;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_addsub;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_alu;

    assign in_ready = !r_ex_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_retire = r_ex_valid && out_ready;

    regfile_np #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .ra1       (rs1),
        .ra2       (rs2),
        .rd1       (w_rf_rd1),
        .rd2       (w_rf_rd2),
        .wr_en     (w_retire && r_ex_we),
        .wr_addr   (r_ex_rd),
        .wr_data   (r_ex_result),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata)
    );

    // Forward the EX result to a dependent issue; x0 never forwards.
    assign w_op1 = (r_ex_valid && r_ex_we && (r_ex_rd != '0) && (r_ex_rd == rs1))
                   ? r_ex_result : w_rf_rd1;
    assign w_op2 = (r_ex_valid && r_ex_we && (r_ex_rd != '0) && (r_ex_rd == rs2))
                   ? r_ex_result : w_rf_rd2;

    assign w_addsub = op_uses_sub(alu_op) ? (w_op1 - w_op2) : (w_op1 + w_op2);
    assign w_shamt  = w_op2[SHW-1:0];

    always_comb begin
        // NOTE: default first so unlisted encodings cannot infer a latch.
        w_alu = '0;
        case (alu_op)
            ALU_ADD, ALU_SUB: w_alu = w_addsub;
            ALU_AND:          w_alu = w_op1 & w_op2;
            ALU_OR:           w_alu = w_op1 | w_op2;
            ALU_XOR:          w_alu = w_op1 ^ w_op2;
            ALU_SLL:          w_alu = w_op1 << w_shamt;
            ALU_SRL:          w_alu = w_op1 >> w_shamt;
            ALU_SRA:          w_alu = XLEN'($signed(w_op1) >>> w_shamt);
            ALU_SLT:          w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op1) < $signed(w_op2))};
            ALU_SLTU:         w_alu = {{(XLEN-1){1'b0}}, (w_op1 < w_op2)};
            default:          w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_we      <= 1'b0;
            r_ex_rd      <= '0;
            r_ex_result  <= '0;
            r_retire_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_ex_valid  <= 1'b1;
                r_ex_we     <= reg_write;
                r_ex_rd     <= rd;
                r_ex_result <= w_alu;
            end else if (w_retire) begin
                r_ex_valid <= 1'b0;
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign out_valid  = r_ex_valid;
    assign out_result = r_ex_result;
    assign out_rd     = r_ex_rd;
    assign retire_cnt = r_retire_cnt;

endmodule : datapath_pipe

// File: tb/tb_datapath_pipe.sv
// Directed bench for datapath_pipe: handshakes, forwarding, backpressure,
// ALU operations, mid-flight reset and debug/retire write collision.
module tb_datapath_pipe;
    import alu_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   rs1, rs2, rd;
    logic            reg_write;
    alu_op_t         alu_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [AW-1:0]   out_rd;
    logic            dbg_we;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_wdata;
    logic [XLEN-1:0] dbg_rdata;
    logic [31:0]     retire_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .retire_cnt (retire_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        tick();
        dbg_we = 1'b0;
    endtask

    task automatic read_reg(input logic [AW-1:0] a, output logic [XLEN-1:0] v);
        dbg_addr = a;
        #1;
        v = dbg_rdata;
    endtask

    // Presents one operation for exactly one edge; in_ready must be high.
    task automatic issue(input alu_op_t op, input logic [AW-1:0] d,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        alu_op = op; rd = d; rs1 = s1; rs2 = s2; reg_write = 1'b1; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [XLEN-1:0] v;
        do_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        if (out_result !== '0) begin errors++; $display("FAIL rst_out_result: got %h need 0", out_result); end
        if (out_rd !== '0) begin errors++; $display("FAIL rst_out_rd: got %0d need 0", out_rd); end
        if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_retire_cnt: got %0d need 0", retire_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        read_reg(5'd1, v);
        checks++;
        if (v !== '0) begin errors++; $display("FAIL rst_rf_x1: got %h need 0", v); end
    endtask

    task automatic test_add();
        logic [XLEN-1:0] v;
        dbg_write(5'd1, 32'd10);
        dbg_write(5'd2, 32'd20);
        read_reg(5'd1, v);
        checks++;
        if (v !== 32'd10) begin errors++; $display("FAIL dbg_preload_x1: got %0d need 10", v); end
        out_ready = 1'b1;
        issue(ALU_ADD, 5'd3, 5'd1, 5'd2);
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b need 1", out_valid); end
        if (out_result !== 32'd30) begin errors++; $display("FAIL add_result: got %0d need 30", out_result); end
        if (out_rd !== 5'd3) begin errors++; $display("FAIL add_rd: got %0d need 3", out_rd); end
        tick();
        read_reg(5'd3, v);
        checks += 3;
        if (v !== 32'd30) begin errors++; $display("FAIL add_x3: got %0d need 30", v); end
        if (retire_cnt !== 32'd1) begin errors++; $display("FAIL add_retire_cnt: got %0d need 1", retire_cnt); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: out_valid=%b need 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] v;
        out_ready = 1'b1;
        issue(ALU_ADD, 5'd3, 5'd1, 5'd2);
        checks++;
        if (out_result !== 32'd30) begin errors++; $display("FAIL b2b_first: got %0d need 30", out_result); end
        issue(ALU_ADD, 5'd4, 5'd3, 5'd1);
        checks += 2;
        if (out_result !== 32'd40) begin errors++; $display("FAIL b2b_bypass: got %0d need 40", out_result); end
        if (out_rd !== 5'd4) begin errors++; $display("FAIL b2b_rd: got %0d need 4", out_rd); end
        tick();
        read_reg(5'd4, v);
        checks += 2;
        if (v !== 32'd40) begin errors++; $display("FAIL b2b_x4: got %0d need 40", v); end
        if (retire_cnt !== 32'd3) begin errors++; $display("FAIL b2b_retire_cnt: got %0d need 3", retire_cnt); end
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] v;
        out_ready = 1'b0;
        issue(ALU_SUB, 5'd3, 5'd2, 5'd1);
        for (int i = 0; i < 3; i++) begin
            read_reg(5'd3, v);
            checks += 5;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b need 1", i, out_valid); end
            if (out_result !== 32'd10) begin errors++; $display("FAIL bp_result[%0d]: got %0d need 10", i, out_result); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b need 0", i, in_ready); end
            if (v !== 32'd30) begin errors++; $display("FAIL bp_x3_held[%0d]: got %0d need 30", i, v); end
            if (retire_cnt !== 32'd3) begin errors++; $display("FAIL bp_cnt_held[%0d]: got %0d need 3", i, retire_cnt); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b need 1", in_ready); end
        tick();
        tick();
        read_reg(5'd3, v);
        checks += 3;
        if (v !== 32'd10) begin errors++; $display("FAIL bp_x3_written: got %0d need 10", v); end
        if (retire_cnt !== 32'd4) begin errors++; $display("FAIL bp_single_retire: got %0d need 4", retire_cnt); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: out_valid=%b need 0", out_valid); end
    endtask

    typedef struct {
        alu_op_t         op;
        logic [AW-1:0]   d, s1, s2;
        logic [XLEN-1:0] exp;
    } vec_t;

    task automatic test_alu_ops();
        vec_t vecs[9];
        logic [XLEN-1:0] v;
        vecs[0] = '{ALU_SUB,  5'd5,  5'd1, 5'd2, 32'hFFFF_FFF6};
        vecs[1] = '{ALU_SLT,  5'd6,  5'd5, 5'd1, 32'd1};
        vecs[2] = '{ALU_SLTU, 5'd7,  5'd5, 5'd1, 32'd0};
        vecs[3] = '{ALU_ADD,  5'd0,  5'd1, 5'd2, 32'd30};
        vecs[4] = '{ALU_SRA,  5'd9,  5'd5, 5'd1, 32'hFFFF_FFFF};
        vecs[5] = '{ALU_SRL,  5'd10, 5'd5, 5'd1, 32'h003F_FFFF};
        vecs[6] = '{ALU_SLL,  5'd11, 5'd1, 5'd1, 32'h0000_2800};
        vecs[7] = '{ALU_AND,  5'd12, 5'd1, 5'd2, 32'd0};
        vecs[8] = '{ALU_XOR,  5'd13, 5'd1, 5'd2, 32'd30};
        out_ready = 1'b1;
        dbg_write(5'd3, 32'd30);
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].d, vecs[i].s1, vecs[i].s2);
            checks += 2;
            if (out_result !== vecs[i].exp)
                begin errors++; $display("FAIL alu_%s: got %h need %h", vecs[i].op.name(), out_result, vecs[i].exp); end
            if (out_rd !== vecs[i].d)
                begin errors++; $display("FAIL alu_%s_rd: got %0d need %0d", vecs[i].op.name(), out_rd, vecs[i].d); end
        end
        tick();
        read_reg(5'd0, v);
        checks++;
        if (v !== '0) begin errors++; $display("FAIL x0_zero: got %h need 0", v); end
        read_reg(5'd6, v);
        checks++;
        if (v !== 32'd1) begin errors++; $display("FAIL slt_x6: got %h need 1", v); end
        checks++;
        if (retire_cnt !== 32'd13) begin errors++; $display("FAIL alu_retire_cnt: got %0d need 13", retire_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [XLEN-1:0] v;
        out_ready = 1'b0;
        issue(ALU_ADD, 5'd8, 5'd1, 5'd2);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending: out_valid=%b need 1", out_valid); end
        do_reset();
        out_ready = 1'b1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b need 0", out_valid); end
        if (out_result !== '0) begin errors++; $display("FAIL rmid_result: got %h need 0", out_result); end
        if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rmid_cnt: got %0d need 0", retire_cnt); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b need 1", in_ready); end
        tick();
        read_reg(5'd8, v);
        checks += 2;
        if (v !== '0) begin errors++; $display("FAIL rmid_x8: got %h need 0", v); end
        if (retire_cnt !== 32'd0) begin errors++; $display("FAIL rmid_no_retire: got %0d need 0", retire_cnt); end
        read_reg(5'd1, v);
        checks++;
        if (v !== '0) begin errors++; $display("FAIL rmid_x1_cleared: got %h need 0", v); end
    endtask

    task automatic test_dbg_collision();
        logic [XLEN-1:0] v;
        dbg_write(5'd1, 32'd10);
        dbg_write(5'd2, 32'd20);
        out_ready = 1'b0;
        issue(ALU_ADD, 5'd3, 5'd1, 5'd2);
        dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'd99; out_ready = 1'b1;
        tick();
        dbg_we = 1'b0;
        read_reg(5'd3, v);
        checks += 2;
        if (v !== 32'd30) begin errors++; $display("FAIL collide_x3: got %0d need 30", v); end
        if (retire_cnt !== 32'd1) begin errors++; $display("FAIL collide_cnt: got %0d need 1", retire_cnt); end
        dbg_write(5'd0, 32'd5);
        read_reg(5'd0, v);
        checks++;
        if (v !== '0) begin errors++; $display("FAIL dbg_x0_write: got %h need 0", v); end
        dbg_write(5'd3, 32'd77);
        read_reg(5'd3, v);
        checks++;
        if (v !== 32'd77) begin errors++; $display("FAIL dbg_write_x3: got %0d need 77", v); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; reg_write = 1'b0;
        alu_op = ALU_ADD; out_ready = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_alu_ops();
        test_reset_mid();
        test_dbg_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_datapath_pipe

// File: doc/datapath_pipe.md
# datapath_pipe

Two-stage pipelined register-file + ALU datapath. It generalises the single-cycle mini datapath with parametrised data width and register count, and adds valid/ready handshakes on issue and result. It forwards an in-flight result to a dependent operation, exposes a debug preload/read port so benches need no hierarchical pokes, and counts retired operations. It sits between a future decode/issue stage and writeback/observation logic.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREG, 32, number of architectural registers (power of two, ≥2); register 0 reads as zero
- AW, $clog2(NREG), register address width (derived, not overridden)
- clk  in  1  clock, rising edge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- in_valid  in  1  issue request valid
- in_ready  out  1  issue accepted when in_valid && in_ready
- rs1, rs2  in  AW  source register addresses
- rd  in  AW  destination register address
- reg_write  in  1  operation writes rd on retire
- alu_op  in  alu_op_t  ALU operation (alu_pkg)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  XLEN  ALU result
- out_rd  out  AW  destination of presented result
- dbg_we  in  1  debug preload write enable
- dbg_addr  in  AW  debug write/read address
- dbg_wdata  in  XLEN  debug write data
- dbg_rdata  out  XLEN  combinational read of rf[dbg_addr] (0 for address 0)
- retire_cnt  out  32  count of completed result handshakes

## Operation
- Stage 1 (issue/execute), combinational:
  - read rs1/rs2;
  - apply bypass;
  - compute the ALU result.
- On accept, latch result, rd and reg_write into the EX register and set ex_valid.
- Stage 2 (EX register) drives out_* while ex_valid.
- Retire happens on out_valid && out_ready. At retire:
  - if reg_write && rd≠0, write the result into rf;
  - increment retire_cnt;
  - clear ex_valid unless a new issue is accepted on the same edge.
- in_ready = !ex_valid || out_ready (combinational; no bubble on streaming).
- Bypass: if ex_valid && ex reg_write && ex_rd≠0 && ex_rd==rsN, operand N = EX result, otherwise rf[rsN]. Address 0 always yields 0.
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Add/sub wrap modulo 2^XLEN.
  - Shift amount = low $clog2(XLEN) bits of operand 2.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Debug write: rf[dbg_addr] ← dbg_wdata on the edge when dbg_we, ignored for address 0. If a retire writes the same address on the same edge, the retire wins.
- Writes to register 0 are discarded everywhere.

## Timing
- Reset (rst high at an edge):
  - out_valid=0, out_result=0, out_rd=0, retire_cnt=0;
  - all rf entries = 0;
  - in_ready=1 from the following cycle.
- Reset mid-operation: the in-flight EX entry is dropped and never written to rf.
- Latency: accepted at edge N → out_valid high after edge N; earliest retire at edge N+1. Throughput is 1 op/cycle with out_ready held high.
- Under backpressure (out_valid && !out_ready):
  - out_result and out_rd are stable;
  - in_ready=0;
  - no rf write;
  - retire_cnt holds.
- retire_cnt wraps from 0xFFFFFFFF to 0.
- Inputs are sampled only when in_valid && in_ready. Other values are don't-care.

## Structure
- alu_pkg owns alu_op_t (enum including all ops above) and the shared op decode. No new package is needed.
- Sub-module regfile_np:
  - parameters XLEN and NREG;
  - two combinational read ports, one debug read port;
  - one write port with retire/debug priority;
  - x0 hardwired to zero.
- The existing ALU function/module is reused, parametrised by XLEN. Bypass mux, EX register, handshake and counter live in the top level.

## Test plan
- Preload x1=10, x2=20 via dbg; issue ADD x3,x1,x2 with out_ready=1 → out_result=30, out_rd=3 one cycle after accept; dbg_rdata(x3)=30; retire_cnt=1.
- Back-to-back ADD x3,x1,x2 then ADD x4,x3,x1 on consecutive cycles → second out_result=40 via bypass; x4=40.
- Hold out_ready=0 for 3 cycles after an issue → out_result held, in_ready=0, x3 unchanged, retire_cnt unchanged. Release → exactly one write and retire_cnt+1.
- SUB x5,x1,x2 → 0xFFFFFFF6; SLT x6,x5,x1 → 1; SLTU x7,x5,x1 → 0; ADD x0,x1,x2 → out_result=30 but x0 reads 0.
- Assert rst while out_valid=1 with a pending write to x8 → outputs return to reset values, x8=0, retire_cnt=0.
- Same-edge dbg_we to x3 (value 99) and retire writing x3=30 → x3=30.
